// File: rtl/booth_mac_accumulator_if.sv
// Handshake bundle between the Booth multiplier, the MAC accumulator and the result sink.
// sat_flag only exists when SATURATE_EN is defined.
interface booth_mac_accumulator_if #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 4
);
    logic signed [7:0]       prod_in;
    logic                    prod_valid;
    logic                    prod_ready;
    logic [CNT_W-1:0]        len;
    logic                    clear;
    logic signed [ACC_W-1:0] acc_out;
    logic                    acc_valid;
    logic                    acc_ready;
    logic                    busy;
`ifdef SATURATE_EN
    logic                    sat_flag;
`endif

    modport slave (
        input  prod_in, prod_valid, len, clear, acc_ready,
        output prod_ready, acc_out, acc_valid, busy
`ifdef SATURATE_EN
        , output sat_flag
`endif
    );

    modport master (
        output prod_in, prod_valid, len, clear, acc_ready,
        input  prod_ready, acc_out, acc_valid, busy
`ifdef SATURATE_EN
        , input sat_flag
`endif
    );
endinterface

// File: rtl/booth_mac_accumulator.sv
// Frame accumulator for signed 8-bit Booth products with a valid/ready result port.
// Define SATURATE_EN to clamp each add to the ACC_W signed range and expose sat_flag.
module booth_mac_accumulator #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    booth_mac_accumulator_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]        r_len_q, w_len_q_nxt;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_add;
    logic [CNT_W-1:0]        w_len_eff;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic                    w_accept;
    logic                    w_ovf;
    logic                    r_sat, w_sat_nxt;

    assign w_ext     = ACC_W'(bus.prod_in);
    assign w_len_eff = (bus.len == '0) ? CNT_W'(1) : bus.len;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_accept  = bus.prod_valid & bus.prod_ready;

`ifdef SATURATE_EN
    // One guard bit exposes signed overflow; clamp toward the sign of the true sum.
    logic [ACC_W:0] w_sum_wide;
    assign w_sum_wide = {r_acc[ACC_W-1], r_acc} + {w_ext[ACC_W-1], w_ext};
    assign w_ovf      = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];
    assign w_add      = !w_ovf ? w_sum_wide[ACC_W-1:0]
                      : (w_sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}});
`else
    assign w_ovf = 1'b0;
    assign w_add = r_acc + w_ext;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_len_q_nxt = r_len_q;
        w_sat_nxt   = r_sat;
        if (bus.clear) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_len_q_nxt = '0;
            w_sat_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_acc_nxt   = w_ext;
                        w_cnt_nxt   = CNT_W'(1);
                        w_len_q_nxt = w_len_eff;
                        w_sat_nxt   = 1'b0;
                        w_state_nxt = (w_len_eff == CNT_W'(1)) ? S_HOLD : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        w_acc_nxt = w_add;
                        w_cnt_nxt = w_cnt_inc;
                        w_sat_nxt = r_sat | w_ovf;
                        if (w_cnt_inc == r_len_q) w_state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.acc_ready) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len_q <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len_q <= w_len_q_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    // prod_ready is gated by reset so nothing is accepted while held in reset.
    assign bus.prod_ready = rst_n & (r_state != S_HOLD);
    assign bus.acc_valid  = (r_state == S_HOLD);
    assign bus.busy       = (r_state == S_ACCUM);
    assign bus.acc_out    = r_acc;
`ifdef SATURATE_EN
    assign bus.sat_flag   = r_sat;
`endif

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed bench for booth_mac_accumulator; frame sums go through a scoreboard queue.
module tb_booth_mac_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_mac_accumulator_if #(.ACC_W(16), .CNT_W(4)) a();
    booth_mac_accumulator_if #(.ACC_W(8),  .CNT_W(4)) b();

    booth_mac_accumulator #(.ACC_W(16), .CNT_W(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
    booth_mac_accumulator #(.ACC_W(8),  .CNT_W(4)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

    int n_chk  = 0;
    int n_fail = 0;
    int sb[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic send_a(input int p);
        int w;
        w = 0;
        a.prod_in    = 8'(p);
        a.prod_valid = 1'b1;
        while (!a.prod_ready && w < 20) begin
            step();
            w++;
        end
        if (w >= 20) chk("send_a_timeout", 32'(a.prod_ready), 32'd1);
        step();
        a.prod_valid = 1'b0;
    endtask

    task automatic send_b(input int p);
        int w;
        w = 0;
        b.prod_in    = 8'(p);
        b.prod_valid = 1'b1;
        while (!b.prod_ready && w < 20) begin
            step();
            w++;
        end
        if (w >= 20) chk("send_b_timeout", 32'(b.prod_ready), 32'd1);
        step();
        b.prod_valid = 1'b0;
    endtask

    // Result-side monitor: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && a.acc_valid && a.acc_ready) begin
            n_chk++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed result %0d, expected no result", a.acc_out);
            end
            if (sb.size() != 0) chk("sb_result", a.acc_out, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        a.prod_in = '0; a.prod_valid = 1'b0; a.len = '0; a.clear = 1'b0; a.acc_ready = 1'b1;
        b.prod_in = '0; b.prod_valid = 1'b0; b.len = '0; b.clear = 1'b0; b.acc_ready = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        chk("rst_acc_out",    a.acc_out,    0);
        chk("rst_acc_valid",  a.acc_valid,  0);
        chk("rst_busy",       a.busy,       0);
        chk("rst_prod_ready", a.prod_ready, 0);
        chk("rst_b_acc_out",  b.acc_out,    0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_prod_ready", a.prod_ready, 1);

        // 1: back-to-back frame of four
        a.len = 4'd4;
        sb.push_back(35);
        send_a(6);
        chk("t1_busy", a.busy, 1);
        send_a(-12);
        send_a(49);
        chk("t1_valid_early", a.acc_valid, 0);
        send_a(-8);
        chk("t1_valid",      a.acc_valid,  1);
        chk("t1_acc_out",    a.acc_out,    35);
        chk("t1_ready_hold", a.prod_ready, 0);
        chk("t1_busy_hold",  a.busy,       0);
        step();
        chk("t1_idle_valid", a.acc_valid, 0);
        chk("t1_idle_acc",   a.acc_out,   35);

        // 2: sink back-pressure holds the result
        a.acc_ready = 1'b0;
        a.len = 4'd3;
        sb.push_back(-192);
        send_a(-64);
        send_a(-64);
        send_a(-64);
        for (int i = 0; i < 5; i++) begin
            a.prod_valid = 1'b1;
            a.prod_in    = 8'h55;
            chk("t2_hold_valid", a.acc_valid,  1);
            chk("t2_hold_acc",   a.acc_out,    -192);
            chk("t2_hold_ready", a.prod_ready, 0);
            step();
        end
        a.prod_valid = 1'b0;
        a.acc_ready  = 1'b1;
        step();
        chk("t2_idle_valid", a.acc_valid,  0);
        chk("t2_idle_ready", a.prod_ready, 1);
        chk("t2_idle_acc",   a.acc_out,    -192);

        // 3: len=0 behaves as len=1
        a.len = 4'd0;
        sb.push_back(49);
        send_a(49);
        chk("t3_len0_valid", a.acc_valid, 1);
        chk("t3_len0_acc",   a.acc_out,   49);
        chk("t3_len0_busy",  a.busy,      0);
        a.len = 4'd1;
        sb.push_back(49);
        send_a(49);
        chk("t3_len1_valid", a.acc_valid, 1);
        chk("t3_len1_acc",   a.acc_out,   49);

        // 4: gaps between products, len changed mid-frame
        a.len = 4'd5;
        sb.push_back(15);
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) begin
                g = int'($urandom_range(0, 3));
                repeat (g) begin
                    a.prod_valid = 1'b0;
                    a.prod_in    = 8'h7f;
                    step();
                end
            end
            send_a(i);
            if (i == 1) a.len = 4'd2;
            if (i == 4) begin
                chk("t4_busy_4",  a.busy,      1);
                chk("t4_valid_4", a.acc_valid, 0);
            end
        end
        chk("t4_valid", a.acc_valid, 1);
        chk("t4_acc",   a.acc_out,   15);

        // 5a: clear drops the in-flight frame and the product beside it
        a.len = 4'd3;
        send_a(7);
        a.prod_valid = 1'b1;
        a.prod_in    = 8'd9;
        a.clear      = 1'b1;
        step();
        a.clear      = 1'b0;
        a.prod_valid = 1'b0;
        chk("t5_clr_busy",  a.busy,       0);
        chk("t5_clr_valid", a.acc_valid,  0);
        chk("t5_clr_acc",   a.acc_out,    0);
        chk("t5_clr_ready", a.prod_ready, 1);
        repeat (3) step();
        chk("t5_clr_novalid", a.acc_valid, 0);
        sb.push_back(6);
        send_a(2); send_a(2); send_a(2);
        chk("t5_clr_new_acc", a.acc_out, 6);

        // 5b: reset in place of clear
        send_a(7);
        a.prod_valid = 1'b1;
        a.prod_in    = 8'd9;
        rst_n        = 1'b0;
        #1;
        chk("t5_rst_ready_low", a.prod_ready, 0);
        step();
        rst_n        = 1'b1;
        a.prod_valid = 1'b0;
        #1;
        chk("t5_rst_busy",  a.busy,       0);
        chk("t5_rst_valid", a.acc_valid,  0);
        chk("t5_rst_acc",   a.acc_out,    0);
        chk("t5_rst_ready", a.prod_ready, 1);
        sb.push_back(6);
        send_a(2); send_a(2); send_a(2);
        chk("t5_rst_new_acc", a.acc_out, 6);

        // Longest frame the counter allows
        a.len = 4'd15;
        sb.push_back(1905);
        for (int i = 1; i <= 15; i++) begin
            send_a(127);
            if (i == 14) chk("len15_busy_14", a.busy, 1);
        end
        chk("len15_valid", a.acc_valid, 1);
        chk("len15_acc",   a.acc_out,   1905);

        // 6: narrow accumulator overflow
        b.len = 4'd3;
        send_b(100);
        send_b(100);
        send_b(-50);
        chk("t6_valid", b.acc_valid, 1);
`ifdef SATURATE_EN
        chk("t6_sat_acc",  b.acc_out,  77);
        chk("t6_sat_flag", b.sat_flag, 1);
        b.len = 4'd1;
        send_b(1);
        chk("t6_sat_clr_flag", b.sat_flag, 0);
        chk("t6_sat_clr_acc",  b.acc_out,  1);
`else
        chk("t6_wrap_acc", b.acc_out, -106);
`endif

        repeat (3) step();
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
